// File: rtl/data_mem_responder.sv
// data_mem_responder
// ------------------
// Target end of the MEM-stage load/store interface. One request is accepted
// at a time. After acceptance the responder waits LATENCY cycles and then
// raises a one-cycle RespValid strobe. Word, halfword and byte stores are
// supported through per-byte lane enables. Misaligned, out-of-range and
// read+write-at-once requests are rejected with AddrError.
//
// Handshake: a request is accepted on the rising edge where ReqReady=1,
// ReqValid=1 and the request carries an operation (MemRead=1 or
// MemWrite!=00). ReqReady is high only in IDLE. ReqValid in any other state
// is dropped, not queued. RespValid is high for exactly one cycle, LATENCY
// cycles after the accepting edge. ReadData and AddrError are meaningful
// only while RespValid=1 and otherwise hold their last values.
//
// Ports:
//   Clk        in   clock, rising-edge
//   Reset      in   synchronous, active-low reset
//   ReqValid   in   request present
//   Address    in   32-bit byte address
//   WriteData  in   store data (sub-word stores use the low bits)
//   MemWrite   in   2-bit store type: 00 none, 01 word, 10 half, 11 byte
//   MemRead    in   load request
//   ReqReady   out  idle and able to accept
//   RespValid  out  one-cycle response strobe
//   ReadData   out  full aligned word for loads, 0 for stores/errors
//   AddrError  out  request rejected
//   Stall      out  pipeline hold while waiting
//   DbgState   out  FSM state (0 IDLE, 1 WAIT, 2 RESP)

module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [1:0]  MemWrite,
    input  logic        MemRead,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        AddrError,
    output logic        Stall,
    output logic [1:0]  DbgState
);

    localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_mw;
    logic        r_mr;

    logic [31:0] r_read_data;
    logic        r_addr_err;

    logic [31:0] r_mem [0:DEPTH_WORDS-1];

    logic        w_accept;
    logic        w_enter_resp;
    logic [31:0] w_eff_addr;
    logic [31:0] w_eff_wdata;
    logic [1:0]  w_eff_mw;
    logic        w_eff_mr;
    logic        w_err;
    logic        w_commit;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;

    assign w_accept = (r_state == S_IDLE) && ReqValid &&
                      (MemRead || (MemWrite != 2'b00));

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                // r_cnt==1 means this cycle's decrement reaches zero.
                if (r_cnt <= 4'd1) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // With LATENCY=1 the edge entering RESP is the accepting edge itself, so
    // the live inputs are used there because nothing is captured yet.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_eff_addr  = Address;
            w_eff_wdata = WriteData;
            w_eff_mw    = MemWrite;
            w_eff_mr    = MemRead;
        end else begin
            w_eff_addr  = r_addr;
            w_eff_wdata = r_wdata;
            w_eff_mw    = r_mw;
            w_eff_mr    = r_mr;
        end
    end

    assign w_enter_resp = (w_state_next == S_RESP);
    assign w_idx        = w_eff_addr[IDX_W+1:2];

    always_comb begin
        w_err = 1'b0;
        if ((w_eff_mw == 2'b01) && (w_eff_addr[1:0] != 2'b00)) w_err = 1'b1;
        if ((w_eff_mw == 2'b10) && w_eff_addr[0])              w_err = 1'b1;
        if ({2'b00, w_eff_addr[31:2]} >= 32'(DEPTH_WORDS))     w_err = 1'b1;
        if (w_eff_mr && (w_eff_mw != 2'b00))                   w_err = 1'b1;
    end

    // Little-endian lane enables; data is replicated across lanes so each
    // enabled lane picks its byte from the same position.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_eff_wdata;
        case (w_eff_mw)
            2'b01: begin
                w_be     = 4'b1111;
                w_wlanes = w_eff_wdata;
            end
            2'b10: begin
                w_be     = w_eff_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_eff_wdata[15:0]}};
            end
            2'b11: begin
                w_be     = 4'b0001 << w_eff_addr[1:0];
                w_wlanes = {4{w_eff_wdata[7:0]}};
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = w_eff_wdata;
            end
        endcase
    end

    assign w_commit = w_enter_resp && (w_eff_mw != 2'b00) && !w_err;

    // Control and response registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_mw        <= 2'b00;
            r_mr        <= 1'b0;
            r_read_data <= 32'd0;
            r_addr_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= Address;
                r_wdata <= WriteData;
                r_mw    <= MemWrite;
                r_mr    <= MemRead;
                r_cnt   <= LAT_M1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_addr_err  <= w_err;
                r_read_data <= (w_eff_mr && !w_err) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // Storage is not cleared by reset; a reset before the commit edge
    // simply keeps the write from happening.
    always_ff @(posedge Clk) begin
        if (Reset && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    assign ReqReady  = (r_state == S_IDLE);
    assign Stall     = (r_state == S_WAIT);
    assign RespValid = (r_state == S_RESP);
    assign ReadData  = r_read_data;
    assign AddrError = r_addr_err;
    assign DbgState  = r_state;

endmodule
